// File: rtl/bsg_chip_noc_link_gearbox.sv
// Bidirectional wide<->narrow gearbox between a manycore link and one channel-tunnel pair.
// Optional RX pad-bit checking is built when BSG_CHIP_NOC_GEARBOX_PAD_CHECK_EN is defined.
module bsg_chip_noc_link_gearbox #(
  parameter int unsigned wide_width_p   = 10,
  parameter int unsigned narrow_width_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic                      wide_v_i,
  input  logic [wide_width_p-1:0]   wide_data_i,
  output logic                      wide_ready_and_o,
  output logic                      narrow_v_o,
  output logic [narrow_width_p-1:0] narrow_data_o,
  input  logic                      narrow_yumi_i,

  input  logic                      narrow_v_i,
  input  logic [narrow_width_p-1:0] narrow_data_i,
  output logic                      narrow_yumi_o,
  output logic                      wide_v_o,
  output logic [wide_width_p-1:0]   wide_data_o,
  input  logic                      wide_yumi_i,

  output logic                      error_o
);

  localparam int unsigned els_lp        = (wide_width_p + narrow_width_p - 1) / narrow_width_p;
  localparam int unsigned pad_lp        = els_lp * narrow_width_p - wide_width_p;
  localparam int unsigned cnt_width_lp  = (els_lp == 1) ? 1 : $clog2(els_lp);
  localparam int unsigned flat_width_lp = els_lp * narrow_width_p;

  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(els_lp - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // ---------------- TX path ----------------
  logic [0:0]                             tx_state;
  logic [cnt_width_lp-1:0]                tx_cnt;
  logic [wide_width_p-1:0]                tx_data;
  logic [flat_width_lp-1:0]               tx_flat;
  logic [els_lp-1:0][narrow_width_p-1:0]  tx_pieces;
  logic                                   tx_last;
  logic                                   tx_accept;

  assign tx_last          = (tx_cnt == last_cnt_lp);
  assign narrow_v_o       = (tx_state == SEND);
  // Final-piece yumi reopens the input in the same cycle so packets stream without a bubble.
  assign wide_ready_and_o = (tx_state == IDLE) | (narrow_v_o & narrow_yumi_i & tx_last);
  assign tx_accept        = wide_v_i & wide_ready_and_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
    end else if (tx_accept) begin
      tx_state <= SEND;
      tx_cnt   <= '0;
    end else if (narrow_v_o & narrow_yumi_i) begin
      if (tx_last) begin
        tx_state <= IDLE;
        tx_cnt   <= '0;
      end else begin
        tx_cnt <= tx_cnt + cnt_width_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_accept) tx_data <= wide_data_i;
  end

  always_comb begin
    tx_flat                 = '0;
    tx_flat[wide_width_p-1:0] = tx_data;
  end

  assign tx_pieces     = tx_flat;
  assign narrow_data_o = tx_pieces[tx_cnt];

  // ---------------- RX path ----------------
  logic [cnt_width_lp-1:0]                rx_cnt;
  logic [els_lp-2:0][narrow_width_p-1:0]  rx_asm;
  logic [flat_width_lp-1:0]               rx_flat;
  logic                                   rx_last;
  logic                                   rx_done;
  logic                                   wide_v_r;
  logic [wide_width_p-1:0]                wide_data_r;

  assign narrow_yumi_o = narrow_v_i & (~wide_v_r | wide_yumi_i);
  assign rx_last       = (rx_cnt == last_cnt_lp);
  assign rx_done       = narrow_yumi_o & rx_last;
  assign rx_flat       = {narrow_data_i, rx_asm};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_cnt   <= '0;
      wide_v_r <= 1'b0;
    end else begin
      if (narrow_yumi_o) rx_cnt <= rx_last ? '0 : rx_cnt + cnt_width_lp'(1);
      if (rx_done)          wide_v_r <= 1'b1;
      else if (wide_yumi_i) wide_v_r <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (narrow_yumi_o & ~rx_last) begin
      for (int unsigned i = 0; i < els_lp - 1; i++) begin
        if (rx_cnt == cnt_width_lp'(i)) rx_asm[i] <= narrow_data_i;
      end
    end
    if (rx_done) wide_data_r <= rx_flat[wide_width_p-1:0];
  end

  assign wide_v_o    = wide_v_r;
  assign wide_data_o = wide_data_r;

  // ---------------- pad check ----------------
`ifdef BSG_CHIP_NOC_GEARBOX_PAD_CHECK_EN
  if (pad_lp > 0) begin : g_pad_check
    logic error_r;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        error_r <= 1'b0;
      end else if (rx_done & (|rx_flat[flat_width_lp-1:wide_width_p])) begin
        error_r <= 1'b1;
      end
    end
    assign error_o = error_r;
  end else begin : g_no_pad
    assign error_o = 1'b0;
  end
`else
  assign error_o = 1'b0;
  if (pad_lp > 0) begin : g_pad_unused
    logic unused_pad;
    assign unused_pad = |rx_flat[flat_width_lp-1:wide_width_p];
  end
`endif

endmodule

// File: tb/tb_bsg_chip_noc_link_gearbox.sv
// Directed self-checking bench for bsg_chip_noc_link_gearbox (wide=10, narrow=4: 3 pieces, 2 pad bits).
module tb_bsg_chip_noc_link_gearbox;

  localparam int unsigned W = 10;
  localparam int unsigned N = 4;

`ifdef BSG_CHIP_NOC_GEARBOX_PAD_CHECK_EN
  localparam logic pad_err_exp = 1'b1;
`else
  localparam logic pad_err_exp = 1'b0;
`endif

  logic         clk_i;
  logic         reset_n_i;
  logic         wide_v_i;
  logic [W-1:0] wide_data_i;
  logic         wide_ready_and_o;
  logic         narrow_v_o;
  logic [N-1:0] narrow_data_o;
  logic         narrow_yumi_i;
  logic         narrow_v_i;
  logic [N-1:0] narrow_data_i;
  logic         narrow_yumi_o;
  logic         wide_v_o;
  logic [W-1:0] wide_data_o;
  logic         wide_yumi_i;
  logic         error_o;

  int tests_run    = 0;
  int tests_failed = 0;

  bsg_chip_noc_link_gearbox #(
    .wide_width_p  (W),
    .narrow_width_p(N)
  ) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .wide_v_i        (wide_v_i),
    .wide_data_i     (wide_data_i),
    .wide_ready_and_o(wide_ready_and_o),
    .narrow_v_o      (narrow_v_o),
    .narrow_data_o   (narrow_data_o),
    .narrow_yumi_i   (narrow_yumi_i),
    .narrow_v_i      (narrow_v_i),
    .narrow_data_i   (narrow_data_i),
    .narrow_yumi_o   (narrow_yumi_o),
    .wide_v_o        (wide_v_o),
    .wide_data_o     (wide_data_o),
    .wide_yumi_i     (wide_yumi_i),
    .error_o         (error_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({narrow_v_o, wide_v_o, wide_ready_and_o, narrow_yumi_o, error_o} !== 5'b00100) begin
      tests_failed++;
      $display("FAIL reset_outputs: got {nv,wv,rdy,nyumi,err}=%b expected 00100",
               {narrow_v_o, wide_v_o, wide_ready_and_o, narrow_yumi_o, error_o});
    end
  endtask

  task automatic test_tx_single();
    logic [N-1:0] exp [3] = '{4'h5, 4'hA, 4'h2};
    wide_v_i = 1'b1; wide_data_i = 10'h2A5; narrow_yumi_i = 1'b0;
    #1;
    tests_run++;
    if (wide_ready_and_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL tx_single_idle_ready: got %b expected 1", wide_ready_and_o);
    end
    tick();
    wide_v_i = 1'b0; narrow_yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ({narrow_v_o, narrow_data_o} !== {1'b1, exp[i]}) begin
        tests_failed++;
        $display("FAIL tx_single_piece%0d: got v=%b d=%h expected v=1 d=%h", i, narrow_v_o, narrow_data_o, exp[i]);
      end
      tests_run++;
      if (wide_ready_and_o !== (i == 2)) begin
        tests_failed++;
        $display("FAIL tx_single_ready%0d: got %b expected %b", i, wide_ready_and_o, (i == 2));
      end
      tick();
    end
    narrow_yumi_i = 1'b0;
    #1;
    tests_run++;
    if (narrow_v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL tx_single_idle_after: got narrow_v_o=%b expected 0", narrow_v_o);
    end
  endtask

  task automatic test_tx_back_to_back();
    logic [N-1:0] exp [6] = '{4'h5, 4'hA, 4'h2, 4'hA, 4'h5, 4'h1};
    wide_v_i = 1'b1; wide_data_i = 10'h2A5; narrow_yumi_i = 1'b0;
    tick();
    wide_data_i = 10'h15A; narrow_yumi_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) wide_v_i = 1'b0;
      #1;
      tests_run++;
      if ({narrow_v_o, narrow_data_o} !== {1'b1, exp[i]}) begin
        tests_failed++;
        $display("FAIL tx_b2b_piece%0d: got v=%b d=%h expected v=1 d=%h", i, narrow_v_o, narrow_data_o, exp[i]);
      end
      tick();
    end
    narrow_yumi_i = 1'b0;
    #1;
    tests_run++;
    if (narrow_v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL tx_b2b_idle_after: got narrow_v_o=%b expected 0", narrow_v_o);
    end
  endtask

  task automatic test_rx_backpressure();
    logic [N-1:0] pcs [3] = '{4'h5, 4'hA, 4'h2};
    wide_yumi_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      narrow_v_i = 1'b1; narrow_data_i = pcs[i];
      #1;
      tests_run++;
      if (narrow_yumi_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL rx_accept%0d: got narrow_yumi_o=%b expected 1", i, narrow_yumi_o);
      end
      tick();
    end
    narrow_data_i = 4'h3;
    #1;
    tests_run++;
    if ({wide_v_o, wide_data_o} !== {1'b1, 10'h2A5}) begin
      tests_failed++;
      $display("FAIL rx_packet: got v=%b d=%h expected v=1 d=2a5", wide_v_o, wide_data_o);
    end
    tests_run++;
    if (narrow_yumi_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_full_refuse: got narrow_yumi_o=%b expected 0", narrow_yumi_o);
    end
    tick();
    tests_run++;
    if ({wide_v_o, narrow_yumi_o} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rx_full_hold: got {wv,nyumi}=%b expected 10", {wide_v_o, narrow_yumi_o});
    end
    wide_yumi_i = 1'b1;
    #1;
    tests_run++;
    if (narrow_yumi_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rx_yumi_release: got narrow_yumi_o=%b expected 1", narrow_yumi_o);
    end
    tick();
    wide_yumi_i = 1'b0; narrow_v_i = 1'b0;
    #1;
    tests_run++;
    if (wide_v_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_drained: got wide_v_o=%b expected 0", wide_v_o);
    end
  endtask

  // Slot 0 already holds 0x3 from the backpressure test.
  task automatic test_rx_simultaneous();
    narrow_v_i = 1'b1; narrow_data_i = 4'h4;
    tick();
    narrow_data_i = 4'h1;
    tick();
    narrow_data_i = 4'h9; wide_yumi_i = 1'b1;
    #1;
    tests_run++;
    if ({wide_v_o, wide_data_o, narrow_yumi_o} !== {1'b1, 10'h143, 1'b1}) begin
      tests_failed++;
      $display("FAIL rx_sim_overlap: got v=%b d=%h nyumi=%b expected v=1 d=143 nyumi=1",
               wide_v_o, wide_data_o, narrow_yumi_o);
    end
    tick();
    wide_yumi_i = 1'b0; narrow_data_i = 4'hB;
    tick();
    narrow_data_i = 4'h3;
    tick();
    narrow_v_i = 1'b0;
    #1;
    tests_run++;
    if ({wide_v_o, wide_data_o} !== {1'b1, 10'h3B9}) begin
      tests_failed++;
      $display("FAIL rx_sim_newpkt: got v=%b d=%h expected v=1 d=3b9", wide_v_o, wide_data_o);
    end
    wide_yumi_i = 1'b1;
    tick();
    wide_yumi_i = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    logic [N-1:0] tx_exp [3] = '{4'h6, 4'hC, 4'h3};
    logic [N-1:0] rx_pcs [3] = '{4'h1, 4'h2, 4'h3};
    wide_v_i = 1'b1; wide_data_i = 10'h2A5; narrow_yumi_i = 1'b0;
    tick();
    wide_v_i = 1'b0; narrow_yumi_i = 1'b1;
    narrow_v_i = 1'b1; narrow_data_i = 4'h7;
    tick();
    narrow_yumi_i = 1'b0; narrow_v_i = 1'b0;
    #1;
    reset_n_i = 1'b0;
    #1;
    tests_run++;
    if ({narrow_v_o, wide_v_o, wide_ready_and_o, narrow_yumi_o, error_o} !== 5'b00100) begin
      tests_failed++;
      $display("FAIL reset_async: got {nv,wv,rdy,nyumi,err}=%b expected 00100",
               {narrow_v_o, wide_v_o, wide_ready_and_o, narrow_yumi_o, error_o});
    end
    tick();
    tick();
    tests_run++;
    if ({narrow_v_o, wide_v_o, wide_ready_and_o} !== 3'b001) begin
      tests_failed++;
      $display("FAIL reset_hold: got {nv,wv,rdy}=%b expected 001", {narrow_v_o, wide_v_o, wide_ready_and_o});
    end
    reset_n_i = 1'b1;
    wide_v_i = 1'b1; wide_data_i = 10'h3C6;
    tick();
    wide_v_i = 1'b0; narrow_yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      narrow_v_i = 1'b1; narrow_data_i = rx_pcs[i];
      #1;
      tests_run++;
      if ({narrow_v_o, narrow_data_o} !== {1'b1, tx_exp[i]}) begin
        tests_failed++;
        $display("FAIL reset_tx_piece%0d: got v=%b d=%h expected v=1 d=%h", i, narrow_v_o, narrow_data_o, tx_exp[i]);
      end
      tick();
    end
    narrow_v_i = 1'b0; narrow_yumi_i = 1'b0;
    #1;
    tests_run++;
    if ({wide_v_o, wide_data_o} !== {1'b1, 10'h321}) begin
      tests_failed++;
      $display("FAIL reset_rx_packet: got v=%b d=%h expected v=1 d=321", wide_v_o, wide_data_o);
    end
    wide_yumi_i = 1'b1;
    tick();
    wide_yumi_i = 1'b0;
  endtask

  task automatic test_pad_check();
    logic [N-1:0] bad  [3] = '{4'h1, 4'h2, 4'hE};
    logic [N-1:0] good [3] = '{4'h1, 4'h2, 4'h1};
    for (int i = 0; i < 3; i++) begin
      narrow_v_i = 1'b1; narrow_data_i = bad[i];
      #1;
      tests_run++;
      if (error_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL pad_pre%0d: got error_o=%b expected 0", i, error_o);
      end
      tick();
    end
    narrow_v_i = 1'b0;
    #1;
    tests_run++;
    if ({wide_v_o, wide_data_o} !== {1'b1, 10'h221}) begin
      tests_failed++;
      $display("FAIL pad_packet: got v=%b d=%h expected v=1 d=221", wide_v_o, wide_data_o);
    end
    tests_run++;
    if (wide_data_o[9:8] !== 2'b10) begin
      tests_failed++;
      $display("FAIL pad_top_bits: got %b expected 10", wide_data_o[9:8]);
    end
    tests_run++;
    if (error_o !== pad_err_exp) begin
      tests_failed++;
      $display("FAIL pad_error: got %b expected %b", error_o, pad_err_exp);
    end
    wide_yumi_i = 1'b1;
    tick();
    wide_yumi_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      narrow_v_i = 1'b1; narrow_data_i = good[i];
      tick();
    end
    narrow_v_i = 1'b0;
    #1;
    tests_run++;
    if ({wide_v_o, wide_data_o, error_o} !== {1'b1, 10'h121, pad_err_exp}) begin
      tests_failed++;
      $display("FAIL pad_sticky: got v=%b d=%h err=%b expected v=1 d=121 err=%b",
               wide_v_o, wide_data_o, error_o, pad_err_exp);
    end
    wide_yumi_i = 1'b1;
    tick();
    wide_yumi_i = 1'b0;
  endtask

  initial begin
    reset_n_i     = 1'b0;
    wide_v_i      = 1'b0;
    wide_data_i   = '0;
    narrow_yumi_i = 1'b0;
    narrow_v_i    = 1'b0;
    narrow_data_i = '0;
    wide_yumi_i   = 1'b0;
    tick();
    tick();
    test_reset();
    reset_n_i = 1'b1;
    tick();
    test_tx_single();
    tick();
    test_tx_back_to_back();
    tick();
    test_rx_backpressure();
    test_rx_simultaneous();
    tick();
    test_reset_mid_packet();
    tick();
    test_pad_check();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bsg_chip_noc_link_gearbox.md
# bsg_chip_noc_link_gearbox

Bidirectional width gearbox between a wide manycore then-ready link (forward or reverse packet) and one narrow channel-tunnel input/output pair inside the chip NoC IO link.
- TX path: accepts one wide packet and emits it as `els_lp` narrow pieces, LSB piece first.
- RX path: reassembles `els_lp` narrow pieces from the tunnel into one wide packet.

Both paths run in the NoC clock domain and operate independently.

## Interface
Parameters:
- `wide_width_p`, "inv", wide packet width; must be > `narrow_width_p`.
- `narrow_width_p`, "inv", tunnel payload width (`ct_width_lp` at the instantiation site).
- `els_lp`, derived, `ceil(wide_width_p / narrow_width_p)`; always ≥ 2.
- `pad_lp`, derived, `els_lp*narrow_width_p - wide_width_p`.
- `cnt_width_lp`, derived, `BSG_SAFE_CLOG2(els_lp)`.

Ports:
- Clocking (already decided): one clock; reset is asynchronous and active-low.
- `clk_i` input 1: NoC clock.
- `reset_n_i` input 1: async active-low reset.
- `wide_v_i` input 1: TX wide packet valid.
- `wide_data_i` input `wide_width_p`: TX wide packet.
- `wide_ready_and_o` output 1: TX accept.
- `narrow_v_o` output 1: TX piece valid.
- `narrow_data_o` output `narrow_width_p`: TX piece.
- `narrow_yumi_i` input 1: tunnel consumed the piece; asserted only when `narrow_v_o` is high.
- `narrow_v_i` input 1: RX piece valid.
- `narrow_data_i` input `narrow_width_p`: RX piece.
- `narrow_yumi_o` output 1: RX piece consumed.
- `wide_v_o` output 1: RX reassembled packet valid.
- `wide_data_o` output `wide_width_p`: RX packet.
- `wide_yumi_i` input 1: consumer took the packet; asserted only when `wide_v_o` is high.
- `error_o` output 1: sticky pad error (see Configuration).

## Operation
TX path, states IDLE / SEND:
- IDLE: `wide_ready_and_o`=1. When `wide_v_i` is high, latch `wide_data_i`, clear `tx_cnt`, go to SEND.
- SEND: `narrow_v_o`=1 and `narrow_data_o` = piece `tx_cnt`, i.e. bits `[tx_cnt*narrow_width_p +: narrow_width_p]`.
  - The upper `pad_lp` bits of the last piece are driven 0.
  - On `narrow_yumi_i`, `tx_cnt` increments.
  - On yumi of piece `els_lp-1`: `wide_ready_and_o`=1 in that same cycle (combinational from `narrow_yumi_i`).
    - If `wide_v_i` is also high, the new packet is latched and SEND continues with `tx_cnt`=0 (no bubble).
    - Otherwise the path goes to IDLE.

RX path:
- An assembly register holds pieces 0..`els_lp`-2, indexed by `rx_cnt`. The output register holds the complete packet.
- `narrow_yumi_o = narrow_v_i & (~wide_v_o | wide_yumi_i)`.
- Accepted piece with `rx_cnt` < `els_lp`-1: stored at slot `rx_cnt`; `rx_cnt` increments.
- Accepted piece with `rx_cnt` = `els_lp`-1: the output register loads the assembly contents plus the low `narrow_width_p-pad_lp` bits of this piece. `wide_v_o` is set and `rx_cnt` returns to 0.
- `wide_yumi_i` without a completing piece in the same cycle clears `wide_v_o`.
- A completing piece arriving in the same cycle as `wide_yumi_i` keeps `wide_v_o`=1 with the new data.

## Timing
- Reset values: `narrow_v_o`=0, `wide_v_o`=0, `wide_ready_and_o`=1, `narrow_yumi_o`=0, `error_o`=0, `tx_cnt`=0, `rx_cnt`=0, TX state IDLE. Data registers are not reset.
- TX latency: packet accepted at cycle t gives piece 0 valid at t+1. Sustained throughput is one piece per cycle, so one packet per `els_lp` cycles.
- RX latency: last piece accepted at cycle t gives `wide_v_o` at t+1.
- RX full (`wide_v_o`=1, no `wide_yumi_i`): `narrow_yumi_o`=0 and `rx_cnt` holds. Pieces 0..`els_lp`-2 of the next packet are still refused, because `narrow_yumi_o` requires `~wide_v_o | wide_yumi_i`.
- `narrow_yumi_o` has combinational paths from `narrow_v_i` and `wide_yumi_i`. It has no path from any TX signal.
- Reset asserted mid-packet: both counters clear asynchronously. The partial packet is discarded on both paths with no output glitch beyond the async clear.

## Configuration
- `BSG_CHIP_NOC_GEARBOX_PAD_CHECK_EN` defined: on acceptance of the last RX piece, if any of its upper `pad_lp` bits is nonzero, `error_o` is set and stays set until reset. The packet is still delivered.
- Macro not defined: `error_o` is tied 0 and no check logic is built.
- If `pad_lp` = 0, `error_o` is constant 0 in both builds.

## Test plan
All tests use `wide_width_p`=10, `narrow_width_p`=4 (`els_lp`=3, `pad_lp`=2) unless stated.
- TX single: `wide_data_i`=0x2A5, `narrow_yumi_i` held at 1 → pieces 0x5, 0xA, 0x2 on cycles t+1..t+3; `wide_ready_and_o`=1 again at t+3.
- TX back-to-back: 0x2A5 then 0x15A offered continuously → six consecutive pieces 5, A, 2, A, 5, 1 with no idle cycle.
- RX reassembly plus backpressure: pieces 0x5, 0xA, 0x2 sent with `wide_yumi_i`=0 → `wide_v_o`=1 with data 0x2A5. A following piece 0x3 then sees `narrow_yumi_o`=0 until `wide_yumi_i` pulses.
- RX simultaneous: a completing piece arrives in the cycle `wide_yumi_i` is asserted → `wide_v_o` stays 1 and data updates to the new packet on the next cycle.
- Reset mid-packet: assert `reset_n_i`=0 after one TX piece and one RX piece, then release and send a fresh packet → the fresh packet starts at piece 0 on both paths, and outputs hold their reset values during reset.
- Pad check, macro defined: last RX piece 0xE → `error_o`=1 from the next cycle, sticky, and `wide_data_o[9:8]`=2'b10. With the macro undefined, `error_o` stays 0.
